// File: rtl/prio_enc_pkg.sv
// Shared constants for the registered priority encoder.
// The one-hot GRANT output is enabled by defining PRIO_ENC_ONEHOT_EN.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority core: rotate by the pointer, find the highest set bit, un-rotate.
// The one-hot output exists only when PRIO_ENC_ONEHOT_EN is defined.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [IDX_W-1:0] index,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [WIDTH-1:0] onehot,
`endif
    output logic             any
);

    localparam int SH_W = IDX_W + 1;

    logic [IDX_W-1:0]   eff_ptr;
    logic [SH_W-1:0]    shamt;
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   rot;
    logic [IDX_W-1:0]   pos;
    logic [SH_W-1:0]    sum;

    // Fixed mode is round-robin with the pointer pinned at WIDTH-1, so rot == d.
    // After the shift rot[i] = d[(eff_ptr+1+i) mod WIDTH]; rot[WIDTH-1] is d[eff_ptr].
    always_comb begin
        eff_ptr = (mode == MODE_RR) ? ptr : IDX_W'(WIDTH - 1);
        shamt   = SH_W'(eff_ptr) + SH_W'(1);
        dd      = {d, d};
        rot     = WIDTH'(dd >> shamt);
        pos     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rot[i]) pos = IDX_W'(i);
        end
        sum = SH_W'(eff_ptr) + SH_W'(1) + SH_W'(pos);
        if (sum >= SH_W'(WIDTH)) sum = sum - SH_W'(WIDTH);
        any   = |d;
        index = any ? sum[IDX_W-1:0] : '0;
    end

`ifdef PRIO_ENC_ONEHOT_EN
    always_comb begin
        onehot = '0;
        if (any) onehot = WIDTH'(1) << index;
    end
`endif

endmodule

// File: rtl/prio_enc_pipe.sv
// Registered priority encoder with valid/ready handshake and fixed/round-robin modes.
// Defining PRIO_ENC_ONEHOT_EN adds the registered one-hot GRANT output.
module prio_enc_pipe
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic             rr_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] q,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [WIDTH-1:0] grant,
`endif
    output logic             any
);

    logic             accept;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_p0;
    logic             any_p0;
    logic             vld_p1;
    logic [IDX_W-1:0] q_p1;
    logic             any_p1;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [WIDTH-1:0] oh_p0;
    logic [WIDTH-1:0] grant_p1;
`endif

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // stage p0: combinational encode of the offered vector
    prio_enc_core #(.WIDTH(WIDTH)) u_core (
        .d      (d),
        .ptr    (ptr),
        .mode   (rr_mode),
        .index  (idx_p0),
`ifdef PRIO_ENC_ONEHOT_EN
        .onehot (oh_p0),
`endif
        .any    (any_p0)
    );

    // Next pointer wraps explicitly to WIDTH-1, which matters for non-power-of-two widths.
    assign ptr_nxt = (idx_p0 == '0) ? IDX_W'(WIDTH - 1) : idx_p0 - IDX_W'(1);

    // stage p1: output registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ptr    <= IDX_W'(WIDTH - 1);
        end else if (accept) begin
            vld_p1 <= 1'b1;
            if (rr_mode == MODE_RR && any_p0) ptr <= ptr_nxt;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1   <= '0;
            any_p1 <= 1'b0;
        end else if (accept) begin
            q_p1   <= idx_p0;
            any_p1 <= any_p0;
        end
    end

`ifdef PRIO_ENC_ONEHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_p1 <= '0;
        else if (accept) grant_p1 <= oh_p0;
    end
    assign grant = grant_p1;
`endif

    assign out_valid = vld_p1;
    assign q         = q_p1;
    assign any       = any_p1;

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Directed self-checking bench for prio_enc_pipe at WIDTH=8 and WIDTH=5.
// Define PRIO_ENC_ONEHOT_EN to also exercise the GRANT output.
`timescale 1ns/1ps
module tb_prio_enc_pipe;

    logic       clk;
    logic       rst_n;
    int         errors;
    int         checks;

    logic       in_valid8, in_ready8, rr8, out_valid8, out_ready8, any8;
    logic [7:0] d8;
    logic [2:0] q8;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [7:0] grant8;
    logic [4:0] grant5;
`endif

    logic       in_valid5, in_ready5, rr5, out_valid5, out_ready5, any5;
    logic [4:0] d5;
    logic [2:0] q5;

    prio_enc_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .d(d8), .rr_mode(rr8), .out_valid(out_valid8), .out_ready(out_ready8),
        .q(q8),
`ifdef PRIO_ENC_ONEHOT_EN
        .grant(grant8),
`endif
        .any(any8)
    );

    prio_enc_pipe #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .d(d5), .rr_mode(rr5), .out_valid(out_valid5), .out_ready(out_ready5),
        .q(q5),
`ifdef PRIO_ENC_ONEHOT_EN
        .grant(grant5),
`endif
        .any(any5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send8(input logic [7:0] v, input logic m);
        d8 = v; rr8 = m; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send5(input logic [4:0] v, input logic m);
        d5 = v; rr5 = m; in_valid5 = 1'b1; out_ready5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", out_valid8); end
        checks++; if (q8 !== 3'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", q8); end
        checks++; if (any8 !== 1'b0) begin errors++; $display("FAIL reset_any: got %0b expected 0", any8); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b expected 1", in_ready8); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL idle_vld: got %0b expected 0", out_valid8); end
    endtask

    task automatic test_fixed();
        send8(8'b0010_1100, 1'b0);
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL fixed_vld: got %0b expected 1", out_valid8); end
        checks++; if (q8 !== 3'd5) begin errors++; $display("FAIL fixed_q: got %0d expected 5", q8); end
        checks++; if (any8 !== 1'b1) begin errors++; $display("FAIL fixed_any: got %0b expected 1", any8); end
`ifdef PRIO_ENC_ONEHOT_EN
        checks++; if (grant8 !== 8'h20) begin errors++; $display("FAIL fixed_grant: got %h expected 20", grant8); end
`endif
        send8(8'h81, 1'b0);
        checks++; if (q8 !== 3'd7) begin errors++; $display("FAIL fixed_msb_q: got %0d expected 7", q8); end
    endtask

    task automatic test_empty();
        send8(8'h00, 1'b1);
        checks++; if (q8 !== 3'd0) begin errors++; $display("FAIL empty_q: got %0d expected 0", q8); end
        checks++; if (any8 !== 1'b0) begin errors++; $display("FAIL empty_any: got %0b expected 0", any8); end
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL empty_vld: got %0b expected 1", out_valid8); end
`ifdef PRIO_ENC_ONEHOT_EN
        checks++; if (grant8 !== 8'h00) begin errors++; $display("FAIL empty_grant: got %h expected 00", grant8); end
`endif
        send8(8'h01, 1'b0);
        checks++; if (q8 !== 3'd0) begin errors++; $display("FAIL bit0_q: got %0d expected 0", q8); end
        checks++; if (any8 !== 1'b1) begin errors++; $display("FAIL bit0_any: got %0b expected 1", any8); end
    endtask

    // Pointer is still 7 here, so the sweep starts at 7.
    task automatic test_rr_sweep();
        logic [2:0] exp_q;
        for (int i = 0; i < 9; i++) begin
            exp_q = 3'(7 - (i % 8));
            send8(8'hFF, 1'b1);
            checks++; if (q8 !== exp_q) begin errors++; $display("FAIL sweep_q[%0d]: got %0d expected %0d", i, q8, exp_q); end
        end
    endtask

    // After the sweep the pointer is 6.
    task automatic test_rr_wrap();
        send8(8'hFF, 1'b1);
        checks++; if (q8 !== 3'd6) begin errors++; $display("FAIL wrap_pre6: got %0d expected 6", q8); end
        send8(8'hFF, 1'b1);
        checks++; if (q8 !== 3'd5) begin errors++; $display("FAIL wrap_pre5: got %0d expected 5", q8); end
        send8(8'b1010_0000, 1'b1);
        checks++; if (q8 !== 3'd7) begin errors++; $display("FAIL wrap_q: got %0d expected 7", q8); end
`ifdef PRIO_ENC_ONEHOT_EN
        checks++; if (grant8 !== 8'h80) begin errors++; $display("FAIL wrap_grant: got %h expected 80", grant8); end
`endif
        send8(8'h0F, 1'b0);
        checks++; if (q8 !== 3'd3) begin errors++; $display("FAIL mixed_fixed_q: got %0d expected 3", q8); end
        send8(8'hFF, 1'b1);
        checks++; if (q8 !== 3'd6) begin errors++; $display("FAIL ptr_persist_q: got %0d expected 6", q8); end
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL drain_vld: got %0b expected 0", out_valid8); end
        checks++; if (q8 !== 3'd6) begin errors++; $display("FAIL drain_q_hold: got %0d expected 6", q8); end
    endtask

    task automatic test_backpressure();
        send8(8'h10, 1'b0);
        checks++; if (q8 !== 3'd4) begin errors++; $display("FAIL bp_first_q: got %0d expected 4", q8); end
        out_ready8 = 1'b0; d8 = 8'h02; rr8 = 1'b0; in_valid8 = 1'b1;
        #1;
        checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_rdy_low: got %0b expected 0", in_ready8); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid8 !== 1'b1 || q8 !== 3'd4) begin errors++; $display("FAIL bp_hold[%0d]: got vld=%0b q=%0d expected vld=1 q=4", i, out_valid8, q8); end
        end
        out_ready8 = 1'b1;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL bp_rdy_high: got %0b expected 1", in_ready8); end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checks++; if (out_valid8 !== 1'b1 || q8 !== 3'd1) begin errors++; $display("FAIL bp_second: got vld=%0b q=%0d expected vld=1 q=1", out_valid8, q8); end
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %0b expected 0", out_valid8); end
    endtask

    task automatic test_reset_mid();
        send8(8'hFF, 1'b1);
        out_ready8 = 1'b0;
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL rmid_pre_vld: got %0b expected 1", out_valid8); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid8 !== 1'b0 || q8 !== 3'd0 || any8 !== 1'b0) begin errors++; $display("FAIL rmid_clear: got vld=%0b q=%0d any=%0b expected 0 0 0", out_valid8, q8, any8); end
        @(negedge clk); rst_n = 1'b1;
        send8(8'hFF, 1'b1);
        checks++; if (q8 !== 3'd7) begin errors++; $display("FAIL rmid_after_q: got %0d expected 7", q8); end
    endtask

    task automatic test_width5();
        logic [2:0] exp5 [6];
        exp5 = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        for (int i = 0; i < 6; i++) begin
            send5(5'h1F, 1'b1);
            checks++; if (q5 !== exp5[i]) begin errors++; $display("FAIL w5_sweep[%0d]: got %0d expected %0d", i, q5, exp5[i]); end
        end
        send5(5'b00011, 1'b1);
        checks++; if (q5 !== 3'd1) begin errors++; $display("FAIL w5_low_q: got %0d expected 1", q5); end
        send5(5'b10001, 1'b1);
        checks++; if (q5 !== 3'd0) begin errors++; $display("FAIL w5_wrap_q: got %0d expected 0", q5); end
        send5(5'b10001, 1'b1);
        checks++; if (q5 !== 3'd4) begin errors++; $display("FAIL w5_wrap4_q: got %0d expected 4", q5); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        in_valid8 = 1'b0; d8 = '0; rr8 = 1'b0; out_ready8 = 1'b1;
        in_valid5 = 1'b0; d5 = '0; rr5 = 1'b0; out_ready5 = 1'b1;
        test_reset();
        test_fixed();
        test_empty();
        test_rr_sweep();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_width5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_enc_pipe.md
Name: prio_enc_pipe

Overview:
- Parametrised, registered priority encoder; successor to the team's 8-bit combinational encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and returns the encoded index one cycle later.
- Supports a fixed-priority mode (MSB highest) and a round-robin mode with a rotating priority pointer.
- Sits between request sources and downstream arbitration/dispatch logic; full throughput of one vector per cycle.

Parameters:
- WIDTH, 8, number of request bits; legal range 2..256; non-power-of-two allowed.
- IDX_W, $clog2(WIDTH), localparam, index width; not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  request vector D valid.
- IN_READY  out  1  block can accept D this cycle.
- D  in  WIDTH  request vector.
- RR_MODE  in  1  0 = fixed priority, 1 = round-robin; sampled with each accepted D.
- OUT_VALID  out  1  Q/ANY valid.
- OUT_READY  in  1  downstream accepts Q/ANY.
- Q  out  IDX_W  encoded index of the winning bit.
- ANY  out  1  at least one bit of the accepted D was set.

Behaviour:
- Reset (async assert, sync release): OUT_VALID=0, Q=0, ANY=0, PTR=WIDTH-1. Applies mid-transfer; any pending result is discarded.
- IN_READY = !OUT_VALID || OUT_READY. Combinational; no dependence on IN_VALID.
- Accept = IN_VALID && IN_READY. On accept, at the next edge:
  - OUT_VALID=1.
  - Q and ANY are computed from D, RR_MODE and the current PTR.
- If OUT_VALID && OUT_READY && !accept: OUT_VALID=0 at the next edge. Q and ANY keep their last values.
- While OUT_VALID && !OUT_READY, Q and ANY are held stable and IN_READY=0.
- Latency: 1 cycle. Back-to-back accepts are sustained when OUT_READY=1.
- Fixed mode priority order: WIDTH-1, WIDTH-2, ..., 0. Q = highest set bit.
- Round-robin priority order: PTR, PTR-1, ..., 0, WIDTH-1, ..., PTR+1. The wrap goes from 0 to WIDTH-1 explicitly, not to 2^IDX_W-1.
- PTR update, on accept only, when RR_MODE=1 and ANY=1: PTR <= (Q==0) ? WIDTH-1 : Q-1.
- PTR is never updated in fixed mode.
- D=0: Q=0, ANY=0, PTR unchanged. This is distinct from D with only bit 0 set, which gives Q=0, ANY=1.
- Switching RR_MODE between vectors is legal. PTR persists across fixed-mode vectors.
- There is no X output: the invalid-input case is signalled by OUT_VALID=0.

Optional Feature:
- Macro PRIO_ENC_ONEHOT_EN.
- Defined: extra output port GRANT out WIDTH, a registered one-hot copy of the winning bit. It has the same timing and hold rules as Q, resets to 0, and is 0 when ANY=0.
- Undefined: no GRANT port or logic; all other behaviour is identical.

Decomposition:
- Package prio_enc_pkg holds the constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module prio_enc_core, purely combinational: D, PTR, mode -> index, any, onehot. It implements the rotate, find-first-set and un-rotate steps.
- prio_enc_pipe holds the handshake, output registers and PTR.

Test Plan:
- Fixed priority: WIDTH=8, RR_MODE=0, D=8'b0010_1100 accepted -> next cycle OUT_VALID=1, Q=5, ANY=1.
- Empty vs bit 0: D=8'h00 -> Q=0, ANY=0. D=8'h01 -> Q=0, ANY=1. PTR stays 7 in both cases.
- Round-robin sweep: RR_MODE=1, D=8'hFF for 9 consecutive accepts with OUT_READY=1 -> Q sequence is 7,6,5,4,3,2,1,0,7.
- Round-robin wrap: after a grant of 5 (PTR=4), D=8'b1010_0000 -> Q=7, then PTR=6.
- Backpressure: hold OUT_READY=0 while OUT_VALID=1 and offer a new D -> IN_READY=0 and Q held. When OUT_READY rises, the new D is accepted and its result appears one cycle later, with no loss or duplication.
- Reset mid-stream: drop RST_N while OUT_VALID=1 -> OUT_VALID, Q and ANY are 0 immediately. After release, RR_MODE=1 with D=8'hFF gives Q=7.
- WIDTH=5 round-robin: D=5'h1F sweep -> Q sequence is 4,3,2,1,0,4.
